// File: rtl/tt_sel_ctrl.sv
// Design-selection sequencer: synchronises and filters the control pads, tracks the
// selected design address (increment or serial-shift mode) and sequences um_ena/um_rst_n.
module tt_sel_ctrl #(
  parameter int G_X         = 16,
  parameter int G_Y         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int SETTLE      = 8,
  localparam int N_UM = G_X * G_Y,
  localparam int AW   = $clog2(N_UM),
  localparam int XW   = $clog2(G_X),
  localparam int YW   = (G_Y > 1) ? $clog2(G_Y) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctrl_sel_rst_n,
  input  logic          ctrl_sel_inc,
  input  logic          ctrl_ena,
  input  logic          ctrl_mode,
  output logic [AW-1:0] sel_addr,
  output logic [XW-1:0] sel_col,
  output logic [YW-1:0] sel_branch,
  output logic          sel_valid,
  output logic          um_ena,
  output logic          um_rst_n,
  output logic          busy
);

  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int SCW = $clog2(SETTLE);
  localparam int I_RSTN = 0;
  localparam int I_INC  = 1;
  localparam int I_ENA  = 2;
  localparam int I_MODE = 3;
  // Active-low reset and enable idle high so a reset never looks like a pad event.
  localparam logic [3:0]     PAD_RST  = 4'b0101;
  localparam logic [SCW-1:0] SET_LOAD = SCW'(SETTLE - 1);
  localparam logic [SCW-1:0] RST_END  = SCW'(SETTLE - SETTLE / 2);
  localparam logic [AW-1:0]  ADDR_MAX = AW'(N_UM - 1);
  localparam logic [AW-1:0]  GX_V     = AW'(G_X);
  localparam logic [AW:0]    NUM_V    = (AW + 1)'(N_UM);

  typedef enum logic [1:0] {S_HOLD, S_SETTLE, S_RUN} state_t;

  logic [3:0]     pad;
  logic [3:0]     sync_p [SYNC_STAGES];
  logic [3:0]     filt;
  logic [FCW-1:0] fcnt [4];
  logic           inc_d;
  logic           mode_d;
  logic           inc_ev;
  logic           mode_chg;
  logic           hold;
  logic           addr_ev;
  logic [AW-1:0]  addr_nxt;
  state_t         state;
  state_t         state_nxt;
  logic [SCW-1:0] scnt;
  logic [SCW-1:0] scnt_nxt;

  assign pad = {ctrl_mode, ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};

  // Synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= PAD_RST;
    end else begin
      sync_p[0] <= pad;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  // Glitch filter: a new level must persist FILT_LEN samples before it is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= PAD_RST;
      inc_d  <= 1'b0;
      mode_d <= 1'b0;
      for (int k = 0; k < 4; k++) fcnt[k] <= '0;
    end else begin
      inc_d  <= filt[I_INC];
      mode_d <= filt[I_MODE];
      for (int k = 0; k < 4; k++) begin
        if (sync_p[SYNC_STAGES-1][k] == filt[k]) begin
          fcnt[k] <= '0;
        end else if (fcnt[k] == FCW'(FILT_LEN - 1)) begin
          filt[k] <= sync_p[SYNC_STAGES-1][k];
          fcnt[k] <= '0;
        end else begin
          fcnt[k] <= fcnt[k] + FCW'(1);
        end
      end
    end
  end

  assign inc_ev   = filt[I_INC] & ~inc_d;
  assign mode_chg = filt[I_MODE] ^ mode_d;
  assign hold     = ~filt[I_MODE] & ~filt[I_RSTN];
  assign addr_ev  = inc_ev & ~hold;

  // Address update; hold beats a simultaneous increment
  always_comb begin
    addr_nxt = sel_addr;
    if (hold) begin
      addr_nxt = '0;
    end else if (inc_ev) begin
      if (filt[I_MODE]) begin
        addr_nxt = {sel_addr[AW-2:0], filt[I_RSTN]};
      end else begin
        addr_nxt = (sel_addr == ADDR_MAX) ? '0 : sel_addr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_addr <= '0;
      state    <= S_SETTLE;
      scnt     <= SET_LOAD;
    end else begin
      sel_addr <= addr_nxt;
      state    <= state_nxt;
      scnt     <= scnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    if (hold) begin
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_HOLD: begin
          state_nxt = S_SETTLE;
          scnt_nxt  = SET_LOAD;
        end
        S_SETTLE: begin
          if (addr_ev || mode_chg) begin
            scnt_nxt = SET_LOAD;
          end else if (scnt == '0) begin
            state_nxt = S_RUN;
          end else begin
            scnt_nxt = scnt - SCW'(1);
          end
        end
        S_RUN: begin
          if (addr_ev || mode_chg) begin
            state_nxt = S_SETTLE;
            scnt_nxt  = SET_LOAD;
          end
        end
        default: begin
          state_nxt = S_SETTLE;
          scnt_nxt  = SET_LOAD;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state so they follow rst immediately
  always_comb begin
    um_ena   = 1'b0;
    um_rst_n = 1'b0;
    busy     = 1'b1;
    case (state)
      S_SETTLE: um_rst_n = (scnt < RST_END);
      S_RUN: begin
        busy     = 1'b0;
        um_rst_n = 1'b1;
        um_ena   = filt[I_ENA] & sel_valid;
      end
      default: ;
    endcase
  end

  assign sel_valid  = ({1'b0, sel_addr} < NUM_V);
  assign sel_col    = XW'(sel_addr % GX_V);
  assign sel_branch = YW'(sel_addr / GX_V);

endmodule

// File: tb/tb_tt_sel_ctrl.sv
// Bench for tt_sel_ctrl: default-parameter instance checked through an address scoreboard
// plus directed timing checks; a G_X=3/G_Y=3 instance shares the pads for range checks.
module tb_tt_sel_ctrl;
  localparam int SS = 2;
  localparam int FL = 4;
  localparam int ST = 8;
  localparam int GX = 16;
  localparam int NU = 32;

  logic clk = 1'b0;
  logic rst;
  logic p_rstn, p_inc, p_ena, p_mode;

  logic [4:0] a_addr;
  logic [3:0] a_col;
  logic [0:0] a_br;
  logic       a_valid, a_ena, a_rstn, a_busy;
  logic [3:0] b_addr;
  logic [1:0] b_col;
  logic [1:0] b_br;
  logic       b_valid, b_ena, b_rstn, b_busy;

  int         total = 0;
  int         bad = 0;
  int         exp_q[$];
  int         model;
  bit         mon_en = 1'b0;
  logic [4:0] prev_addr = '0;

  tt_sel_ctrl dut (
    .clk(clk), .rst(rst),
    .ctrl_sel_rst_n(p_rstn), .ctrl_sel_inc(p_inc), .ctrl_ena(p_ena), .ctrl_mode(p_mode),
    .sel_addr(a_addr), .sel_col(a_col), .sel_branch(a_br), .sel_valid(a_valid),
    .um_ena(a_ena), .um_rst_n(a_rstn), .busy(a_busy)
  );

  tt_sel_ctrl #(.G_X(3), .G_Y(3)) dut3 (
    .clk(clk), .rst(rst),
    .ctrl_sel_rst_n(p_rstn), .ctrl_sel_inc(p_inc), .ctrl_ena(p_ena), .ctrl_mode(p_mode),
    .sel_addr(b_addr), .sel_col(b_col), .sel_branch(b_br), .sel_valid(b_valid),
    .um_ena(b_ena), .um_rst_n(b_rstn), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed address change must match the next queued expectation
  always @(negedge clk) begin
    int e;
    if (mon_en && a_addr !== prev_addr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_addr_change", 32'(a_addr), 32'(prev_addr));
      end else begin
        e = exp_q.pop_front();
        check("addr", 32'(a_addr), e);
        check("col", 32'(a_col), e % GX);
        check("branch", 32'(a_br), e / GX);
      end
      prev_addr = a_addr;
    end
  end

  task automatic expect_addr(input int n);
    if (n != model) exp_q.push_back(n);
    model = n;
  endtask

  task automatic inc_pulse();
    expect_addr((model == NU - 1) ? 0 : model + 1);
    p_inc = 1'b1;
    repeat (FL + 2) @(negedge clk);
    p_inc = 1'b0;
    repeat (FL + 6) @(negedge clk);
  endtask

  task automatic shift_bit(input bit b);
    int k;
    logic [4:0] old;
    p_rstn = b;
    repeat (SS + FL + 2) @(negedge clk);
    old = a_addr;
    expect_addr(((model * 2) + int'(b)) % NU);
    p_inc = 1'b1;
    k = 0;
    while (a_addr === old && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("shift_latency", k, SS + FL + 1);
    check("shift_rstn_j0", 32'(a_rstn), 0);
    check("shift_busy_j0", 32'(a_busy), 1);
    check("shift_ena_j0", 32'(a_ena), 0);
    p_inc = 1'b0;
    for (int j = 1; j <= ST; j++) begin
      @(negedge clk);
      check("shift_rstn", 32'(a_rstn), 32'(j >= ST / 2));
      check("shift_busy", 32'(a_busy), 32'(j < ST));
      check("shift_ena", 32'(a_ena), 32'(j >= ST));
    end
    repeat (FL + 4) @(negedge clk);
  endtask

  initial begin
    int k;
    p_rstn = 1'b1; p_inc = 1'b0; p_ena = 1'b1; p_mode = 1'b0;
    rst = 1'b1;
    model = 0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(a_addr), 0);
    check("rst_valid", 32'(a_valid), 1);
    check("rst_ena", 32'(a_ena), 0);
    check("rst_rstn", 32'(a_rstn), 0);
    check("rst_busy", 32'(a_busy), 1);
    check("rst_valid3", 32'(b_valid), 1);
    rst = 1'b0;
    mon_en = 1'b1;

    // Power-up settle window
    repeat (3) @(negedge clk);
    check("pwr_rstn_c3", 32'(a_rstn), 0);
    @(negedge clk);
    check("pwr_rstn_c4", 32'(a_rstn), 1);
    repeat (3) @(negedge clk);
    check("pwr_ena_c7", 32'(a_ena), 0);
    check("pwr_busy_c7", 32'(a_busy), 1);
    @(negedge clk);
    check("pwr_ena_c8", 32'(a_ena), 1);
    check("pwr_busy_c8", 32'(a_busy), 0);
    check("pwr_addr", 32'(a_addr), 0);

    // Increment through the full range and wrap
    for (int i = 0; i < 33; i++) inc_pulse();
    repeat (ST) @(negedge clk);
    check("inc_wrap_addr", 32'(a_addr), model);

    // Short inc pulse and a one-cycle sel_rst_n glitch are both filtered out
    check("glitch_pre_busy", 32'(a_busy), 0);
    p_inc = 1'b1;
    repeat (FL - 1) @(negedge clk);
    p_inc = 1'b0;
    repeat (6) @(negedge clk);
    p_rstn = 1'b0;
    @(negedge clk);
    p_rstn = 1'b1;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      check("glitch_busy", 32'(a_busy), 0);
      check("glitch_ena", 32'(a_ena), 1);
    end
    check("glitch_addr", 32'(a_addr), model);

    // Mode change starts a settle window without touching the address
    p_mode = 1'b1;
    repeat (SS + FL) @(negedge clk);
    check("mode_busy_before", 32'(a_busy), 0);
    @(negedge clk);
    check("mode_busy_after", 32'(a_busy), 1);
    check("mode_rstn_after", 32'(a_rstn), 0);
    repeat (ST + 2) @(negedge clk);
    check("mode_busy_done", 32'(a_busy), 0);

    // Serial load 1,0,1,1,0
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    check("shift_addr", 32'(a_addr), 22);
    check("shift_branch", 32'(a_br), 1);
    check("shift_col", 32'(a_col), 6);

    // Back to increment mode, then hold via sel_rst_n
    p_rstn = 1'b1;
    repeat (10) @(negedge clk);
    p_mode = 1'b0;
    repeat (SS + FL + ST + 4) @(negedge clk);
    expect_addr(0);
    p_rstn = 1'b0;
    repeat (SS + FL + 2) @(negedge clk);
    check("hold_addr", 32'(a_addr), 0);
    check("hold_rstn", 32'(a_rstn), 0);
    check("hold_busy", 32'(a_busy), 1);
    check("hold_ena", 32'(a_ena), 0);
    p_rstn = 1'b1;
    repeat (SS + FL + ST + 4) @(negedge clk);
    check("hold_release_busy", 32'(a_busy), 0);

    // Simultaneous inc and sel_rst_n low: reset wins
    for (int i = 0; i < 3; i++) inc_pulse();
    expect_addr(0);
    p_rstn = 1'b0;
    p_inc = 1'b1;
    repeat (10) @(negedge clk);
    check("race_addr", 32'(a_addr), 0);
    check("race_busy", 32'(a_busy), 1);
    p_rstn = 1'b1;
    repeat (10) @(negedge clk);
    p_inc = 1'b0;
    repeat (ST + 10) @(negedge clk);
    check("race_release_addr", 32'(a_addr), 0);
    check("race_release_busy", 32'(a_busy), 0);

    // Reach address 5, then assert rst in the middle of its settle window
    for (int i = 0; i < 4; i++) inc_pulse();
    expect_addr(5);
    p_inc = 1'b1;
    k = 0;
    while (a_addr !== 5'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("addr5_reached", 32'(a_addr), 5);
    repeat (2) @(negedge clk);
    check("addr5_busy", 32'(a_busy), 1);
    expect_addr(0);
    rst = 1'b1;
    #1;
    check("midrst_addr", 32'(a_addr), 0);
    check("midrst_valid", 32'(a_valid), 1);
    check("midrst_ena", 32'(a_ena), 0);
    check("midrst_rstn", 32'(a_rstn), 0);
    check("midrst_busy", 32'(a_busy), 1);
    p_inc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (ST - 1) @(negedge clk);
    check("postrst_busy_c7", 32'(a_busy), 1);
    check("postrst_ena_c7", 32'(a_ena), 0);
    @(negedge clk);
    check("postrst_busy_c8", 32'(a_busy), 0);
    check("postrst_ena_c8", 32'(a_ena), 1);
    check("postrst_addr", 32'(a_addr), 0);
    check("postrst_addr3", 32'(b_addr), 0);

    // Non-power-of-two array: out-of-range shift, then wrap from the last design
    p_mode = 1'b1;
    repeat (SS + FL + ST + 4) @(negedge clk);
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    repeat (4) @(negedge clk);
    check("g3_addr15", 32'(b_addr), 15);
    check("g3_valid15", 32'(b_valid), 0);
    check("g3_ena15", 32'(b_ena), 0);
    check("g3_busy15", 32'(b_busy), 0);
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    check("g3_addr8", 32'(b_addr), 8);
    check("g3_valid8", 32'(b_valid), 1);
    check("g3_branch8", 32'(b_br), 2);
    check("g3_col8", 32'(b_col), 2);
    check("g3_ena8", 32'(b_ena), 1);
    p_rstn = 1'b1;
    repeat (10) @(negedge clk);
    p_mode = 1'b0;
    repeat (SS + FL + ST + 4) @(negedge clk);
    inc_pulse();
    check("g3_wrap_addr", 32'(b_addr), 0);
    check("g3_wrap_col", 32'(b_col), 0);
    check("g3_wrap_branch", 32'(b_br), 0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
